// File: rtl/tt_sweep_checker.sv
// Clocked stimulus/checker for a 3-input, 1-output combinational block.
// Sweeps {a,b,c} = 0..7, samples y after a settle delay, and compares the table to EXPECTED.
module tt_sweep_checker #(
   parameter int unsigned SETTLE   = 2,
   parameter logic [7:0]  EXPECTED = 8'h48
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   output logic       a,
   output logic       b,
   output logic       c,
   input  logic       y,
   output logic       busy,
   output logic       done,
   output logic       result_valid,
   output logic       pass,
   output logic [7:0] tt,
   output logic [3:0] fail_count,
   output logic [2:0] fail_idx
);

   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE} state_t;

   localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

   state_t     state, state_nxt;
   logic [2:0] idx;
   logic [3:0] cnt;
   logic       mismatch;
   logic       busy_nxt;
   logic       done_nxt;

   // The applied vector is the index register itself, so a/b/c stay glitch-free.
   assign {a, b, c} = idx;
   assign mismatch  = (y != EXPECTED[idx]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:   if (start && !abort) state_nxt = ST_SETTLE;
         ST_SETTLE: begin
            if (abort)                state_nxt = ST_IDLE;
            else if (cnt == CNT_LAST) state_nxt = ST_SAMPLE;
         end
         ST_SAMPLE: begin
            if (abort)           state_nxt = ST_IDLE;
            else if (idx == 3'd7) state_nxt = ST_DONE;
            else                 state_nxt = ST_SETTLE;
         end
         ST_DONE:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
      // Status flags are decoded from the next state so they register in step with it.
      busy_nxt = (state_nxt == ST_SETTLE) || (state_nxt == ST_SAMPLE);
      done_nxt = (state_nxt == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx          <= '0;
         cnt          <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         result_valid <= 1'b0;
         pass         <= 1'b0;
         tt           <= '0;
         fail_count   <= '0;
         fail_idx     <= '0;
      end else begin
         busy <= busy_nxt;
         done <= done_nxt;
         unique case (state)
            ST_IDLE: begin
               if (abort || start) begin
                  result_valid <= 1'b0;
                  pass         <= 1'b0;
                  tt           <= '0;
                  fail_count   <= '0;
                  fail_idx     <= '0;
               end
               if (start && !abort) begin
                  idx <= '0;
                  cnt <= '0;
               end
            end
            ST_SETTLE: begin
               if (abort) begin
                  idx <= '0;
                  cnt <= '0;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            ST_SAMPLE: begin
               if (abort) begin
                  idx <= '0;
                  cnt <= '0;
               end else begin
                  tt[idx] <= y;
                  if (mismatch) fail_count <= fail_count + 4'd1;
                  if (mismatch && (fail_count == 4'd0)) fail_idx <= idx;
                  // Verdict includes this last sample so pass rises together with done.
                  if (idx == 3'd7) begin
                     result_valid <= 1'b1;
                     pass         <= (fail_count == 4'd0) && !mismatch;
                  end else begin
                     idx <= idx + 3'd1;
                     cnt <= '0;
                  end
               end
            end
            ST_DONE: ;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Randomized self-checking bench: the function block is a lookup table in the bench,
// and expected results are derived from that table with plain arithmetic.
module tb_tt_sweep_checker;

   localparam logic [7:0] EXP = 8'h48;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start0, abort0, y0, a0, b0, c0, busy0, done0, rv0, pass0;
   logic [7:0] tt0;
   logic [3:0] fc0;
   logic [2:0] fi0;
   logic       start1, abort1, y1, a1, b1, c1, busy1, done1, rv1, pass1;
   logic [7:0] tt1;
   logic [3:0] fc1;
   logic [2:0] fi1;
   logic [7:0] tbl0, tbl1;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   logic [2:0] s_vec;
   logic       s_busy, s_done, s_rv, s_pass;
   logic [7:0] s_tt;
   logic [3:0] s_fc;
   logic [2:0] s_fi;

   always #5 clk = ~clk;

   always_comb y0 = tbl0[{a0, b0, c0}];
   always_comb y1 = tbl1[{a1, b1, c1}];

   tt_sweep_checker #(.SETTLE(2), .EXPECTED(EXP)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
      .a(a0), .b(b0), .c(c0), .y(y0), .busy(busy0), .done(done0),
      .result_valid(rv0), .pass(pass0), .tt(tt0), .fail_count(fc0), .fail_idx(fi0)
   );

   tt_sweep_checker #(.SETTLE(1), .EXPECTED(EXP)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
      .a(a1), .b(b1), .c(c1), .y(y1), .busy(busy1), .done(done1),
      .result_valid(rv1), .pass(pass1), .tt(tt1), .fail_count(fc1), .fail_idx(fi1)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic snap(input bit sel);
      if (sel) begin
         s_vec = {a1, b1, c1}; s_busy = busy1; s_done = done1; s_rv = rv1;
         s_pass = pass1; s_tt = tt1; s_fc = fc1; s_fi = fi1;
      end else begin
         s_vec = {a0, b0, c0}; s_busy = busy0; s_done = done0; s_rv = rv0;
         s_pass = pass0; s_tt = tt0; s_fc = fc0; s_fi = fi0;
      end
   endtask

   function automatic logic [31:0] all_outs();
      return {10'd0, s_vec, s_busy, s_done, s_rv, s_pass, s_tt, s_fc, s_fi};
   endfunction

   function automatic int unsigned model_fc(input logic [7:0] t);
      int unsigned n = 0;
      for (int i = 0; i < 8; i++) if (t[i] != EXP[i]) n++;
      return n;
   endfunction

   function automatic int unsigned model_fi(input logic [7:0] t);
      for (int i = 0; i < 8; i++) if (t[i] != EXP[i]) return i;
      return 0;
   endfunction

   task automatic drive_start(input bit sel, input logic v);
      if (sel) start1 = v; else start0 = v;
   endtask

   // Entered at a negedge with the selected checker idle.
   task automatic run_sweep(input bit sel, input logic [7:0] tbl, input int pulse_at);
      int unsigned per   = sel ? 2 : 3;
      int unsigned total = 8 * per;
      if (sel) tbl1 = tbl; else tbl0 = tbl;
      drive_start(sel, 1'b1);
      @(negedge clk);
      drive_start(sel, 1'b0);
      for (int k = 0; k <= int'(total) + 3; k++) begin
         snap(sel);
         if (k < int'(total)) begin
            check("vec", 32'(s_vec), 32'(k / int'(per)));
            check("busy", 32'(s_busy), 32'd1);
            check("done_early", 32'(s_done), 32'd0);
         end else if (k == int'(total)) begin
            check("done", 32'(s_done), 32'd1);
            check("busy_at_done", 32'(s_busy), 32'd0);
            check("result_valid", 32'(s_rv), 32'd1);
            check("pass", 32'(s_pass), 32'(tbl == EXP));
            check("tt", 32'(s_tt), 32'(tbl));
            check("fail_count", 32'(s_fc), model_fc(tbl));
            check("fail_idx", 32'(s_fi), model_fi(tbl));
         end else begin
            check("done_once", 32'(s_done), 32'd0);
            check("busy_after", 32'(s_busy), 32'd0);
            check("vec_hold", 32'(s_vec), 32'd7);
            check("rv_hold", 32'(s_rv), 32'd1);
         end
         drive_start(sel, k == pulse_at);
         @(negedge clk);
      end
   endtask

   initial begin
      logic [7:0] t;
      bit         saw;
      rst_n = 1'b0;
      start0 = 1'b0; abort0 = 1'b0; start1 = 1'b0; abort1 = 1'b0;
      tbl0 = EXP; tbl1 = EXP;

      // Reset: outputs stay zero while start toggles under reset.
      repeat (3) begin
         @(negedge clk); start0 = ~start0; start1 = ~start1;
      end
      #1;
      snap(0); check("reset_outs0", all_outs(), 32'd0);
      snap(1); check("reset_outs1", all_outs(), 32'd0);
      @(negedge clk);
      start0 = 1'b0; start1 = 1'b0;
      rst_n = 1'b1;
      saw = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (busy0 || done0 || busy1 || done1) saw = 1'b1;
      end
      check("idle_after_reset", 32'(saw), 32'd0);

      // Directed tables: correct block, stuck-at-0, inverted.
      run_sweep(0, EXP, -1);
      run_sweep(0, 8'h00, -1);
      run_sweep(0, 8'hB7, -1);
      for (int r = 0; r < 4; r++) begin
         t = 8'($urandom);
         run_sweep(0, t, -1);
      end

      // Abort in cycle 10 of a sweep over a random table.
      t = 8'($urandom);
      tbl0 = t;
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      repeat (10) @(negedge clk);
      abort0 = 1'b1;
      @(negedge clk);
      abort0 = 1'b0;
      snap(0);
      check("abort_busy", 32'(s_busy), 32'd0);
      check("abort_vec", 32'(s_vec), 32'd0);
      check("abort_rv", 32'(s_rv), 32'd0);
      check("abort_tt", 32'(s_tt), 32'(t & 8'h07));
      saw = 1'b0;
      repeat (30) begin
         if (done0 || busy0) saw = 1'b1;
         @(negedge clk);
      end
      check("abort_no_done", 32'(saw), 32'd0);
      run_sweep(0, EXP, -1);

      // start pulsed mid-sweep is ignored.
      run_sweep(0, 8'($urandom), 5);

      // start and abort together in IDLE.
      start0 = 1'b1; abort0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0; abort0 = 1'b0;
      saw = 1'b0;
      repeat (8) begin
         if (busy0 || done0) saw = 1'b1;
         @(negedge clk);
      end
      check("start_abort_idle", 32'(saw), 32'd0);

      // Reset asserted in cycle 7 of a sweep.
      tbl0 = 8'($urandom);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      #1;
      snap(0); check("midreset_outs", all_outs(), 32'd0);
      @(negedge clk);
      snap(0); check("midreset_hold", all_outs(), 32'd0);
      rst_n = 1'b1;
      saw = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (busy0 || done0) saw = 1'b1;
      end
      check("midreset_no_sweep", 32'(saw), 32'd0);

      // SETTLE=1 instance.
      run_sweep(1, EXP, -1);
      run_sweep(1, 8'($urandom), -1);
      run_sweep(1, 8'hB7, -1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/tt_sweep_checker.md
Name: tt_sweep_checker

Overview:
- Sequential driver/checker for a 3-input, 1-output combinational function block such as the two-AND/XOR equation unit.
- Drives all 8 input vectors {a,b,c} in ascending order and waits a programmable settle time per vector.
- Samples the block's output, builds the observed 8-entry truth table and compares it bit-by-bit against an expected table.
- Replaces hand-written initial/#delay stimulus with a clocked, self-checking stage.

Parameters:
- SETTLE, 2, cycles each vector is held before sampling; legal range 1..15.
- EXPECTED, 8'h48, expected truth table; bit i = required y for vector i, where i = {a,b,c} (a is MSB). 8'h48 encodes y = (a&b)^(b&c).

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a sweep; sampled only in IDLE.
- abort  in  1  terminate the sweep in progress.
- a  out  1  vector bit 2 to the DUT.
- b  out  1  vector bit 1 to the DUT.
- c  out  1  vector bit 0 to the DUT.
- y  in  1  DUT output, combinational from a/b/c.
- busy  out  1  high while the sweep is in progress.
- done  out  1  one-cycle pulse when the sweep completes.
- result_valid  out  1  pass, tt, fail_count and fail_idx are valid.
- pass  out  1  observed table equals EXPECTED.
- tt  out  8  observed truth table; bit i = y sampled for vector i.
- fail_count  out  4  number of mismatching entries, 0..8.
- fail_idx  out  3  lowest vector index that mismatched; 0 if none.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: state IDLE, idx 0, settle counter 0; a/b/c=0; busy, done, result_valid, pass = 0; tt=0, fail_count=0, fail_idx=0. Reset asserted mid-sweep takes effect immediately with no further sampling.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 and abort=0 -> SETTLE; idx<=0, cnt<=0.
  - Clear tt, fail_count, fail_idx and result_valid.
  - abort=1 takes priority over start; stay in IDLE.
- SETTLE:
  - {a,b,c} = idx, driven from registers; busy=1.
  - cnt increments each cycle; when cnt==SETTLE-1 -> SAMPLE.
- SAMPLE:
  - Vector still driven, one cycle.
  - At the closing edge: tt[idx]<=y.
  - If y != EXPECTED[idx]: fail_count+1; fail_idx<=idx if this is the first mismatch.
  - idx==7 -> DONE. Otherwise idx+1, cnt<=0 -> SETTLE.
- DONE, one cycle:
  - done=1; result_valid<=1; pass<=(final fail_count==0).
  - busy=0; next state IDLE.
- Outputs after a sweep: a/b/c hold the last vector (3'b111) until the next start or reset. Results hold until the next accepted start, abort or reset.
- Latency:
  - With the cycle after the start edge as cycle 0, done is high in cycle 8*(SETTLE+1).
  - SETTLE=2 gives cycle 24; SETTLE=1 gives cycle 16.
  - result_valid and pass rise with done.
- Abort:
  - In SETTLE or SAMPLE: -> IDLE at the next edge; busy falls and no done pulse is issued.
  - result_valid stays 0; partial tt is retained for debug; a/b/c return to 0.
  - Abort in the same cycle as the final SAMPLE wins: no sample is taken.
- start while busy is ignored. start held high continuously re-triggers a new sweep from IDLE on the cycle after DONE.
- All outputs are registered; no combinational path from y to any output.
- fail_count cannot exceed 8, so no wrap.

Test Plan:
- Reset: hold rst_n=0, toggle start -> all outputs 0. Release; idle 5 cycles -> busy=0, done=0.
- Correct DUT (y=(a&b)^(b&c)), SETTLE=2, 1-cycle start pulse -> a/b/c sequence 000..111, each held 3 cycles. done in cycle 24; tt=8'h48, pass=1, fail_count=0, fail_idx=0.
- y stuck at 0 -> tt=8'h00, fail_count=2, fail_idx=3, pass=0, result_valid=1.
- Inverted DUT (y=~((a&b)^(b&c))) -> tt=8'hB7, fail_count=8, fail_idx=0, pass=0.
- Abort in cycle 10 -> busy=0 from cycle 11, no done, result_valid=0, a/b/c=0. A fresh start then completes with tt=8'h48, pass=1.
- Control corner cases, each checked separately:
  - start pulsed while busy -> single sweep, done exactly once.
  - start and abort together in IDLE -> no sweep.
  - rst_n low in cycle 7 -> immediate all-zero outputs.
  - SETTLE=1 -> done in cycle 16.
